// File: rtl/hc148_encoder.sv
// Registered 8-to-3 priority encoder with request capture and a valid/ack grant handshake.
// Latency: a request sampled at edge k is pending after k and is granted after k+1; at most one grant per 2 cycles.
// Backpressure: a grant is held on DateA/valid until ack; requests wait in the pending register meanwhile.
module hc148_encoder #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] enable,
  input  logic [7:0] in,
  input  logic       ack,
  output logic [2:0] DateA,
  output logic       valid,
  output logic       gs,
  output logic       eo
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pend;

  logic       w_en;
  logic [7:0] w_clr;
  logic [7:0] w_pend_n;
  logic [2:0] w_sel;
  logic       w_valid_n;

  assign w_en = &enable;

  // Clear only the bit being acknowledged; a new request on that bit wins over the clear.
  always_comb begin
    w_clr    = (valid && ack) ? (8'h01 << DateA) : 8'h00;
    w_pend_n = (r_pend & ~w_clr) | (w_en ? in : 8'h00);
  end

  // Pick the highest-priority pending bit; the last match in scan order wins.
  always_comb begin
    w_sel = 3'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (r_pend[i]) w_sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (r_pend[i]) w_sel = 3'(i);
      end
    end
  end

  // Next value of valid, needed so gs/eo track the state the FSM is about to enter.
  always_comb begin
    w_valid_n = 1'b0;
    case (r_state)
      S_IDLE:    w_valid_n = w_en && (r_pend != 8'h00);
      S_PRESENT: w_valid_n = !ack;
      default:   w_valid_n = 1'b0;
    endcase
  end

  // Grant FSM plus pending register and status flags, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= 8'h00;
      DateA   <= 3'd0;
      valid   <= 1'b0;
      gs      <= 1'b0;
      eo      <= 1'b0;
    end else begin
      r_pend <= w_pend_n;
      gs     <= (w_pend_n != 8'h00) | w_valid_n;
      eo     <= w_en & (w_pend_n == 8'h00) & ~w_valid_n;
      case (r_state)
        S_IDLE: begin
          if (w_en && (r_pend != 8'h00)) begin
            DateA   <= w_sel;
            valid   <= 1'b1;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // No preemption: the presented index stays until the consumer accepts it.
          if (ack) begin
            valid   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          valid   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc148_encoder.sv
// Directed bench for hc148_encoder: one instance per priority order, sharing all inputs.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Grants are waited for with a bounded loop so a missing grant is reported, not hung on.
module tb_hc148_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enable;
  logic [7:0] in;
  logic       ack;

  logic [2:0] hi_DateA, lo_DateA;
  logic       hi_valid, lo_valid;
  logic       hi_gs, lo_gs;
  logic       hi_eo, lo_eo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hc148_encoder #(.PRIO_HIGH(1'b1)) u_dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .ack(ack),
    .DateA(hi_DateA), .valid(hi_valid), .gs(hi_gs), .eo(hi_eo)
  );

  hc148_encoder #(.PRIO_HIGH(1'b0)) u_dut_lo (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .ack(ack),
    .DateA(lo_DateA), .valid(lo_valid), .gs(lo_gs), .eo(lo_eo)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, check both indices, then ack it for one edge.
  task automatic grant_ack(input string tag, input logic [2:0] exp_hi, input logic [2:0] exp_lo);
    int waited = 0;
    while (!hi_valid && waited < 8) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, {7'd0, hi_valid}, 8'd1);
    chk({tag, "_hi"}, {5'd0, hi_DateA}, {5'd0, exp_hi});
    chk({tag, "_lo"}, {5'd0, lo_DateA}, {5'd0, exp_lo});
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_drop"}, {7'd0, hi_valid}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 3'b000; in = 8'h00; ack = 1'b0;

    // Reset then idle
    tick(); tick();
    chk("rst_DateA", {5'd0, hi_DateA}, 8'd0);
    chk("rst_valid", {7'd0, hi_valid}, 8'd0);
    chk("rst_gs",    {7'd0, hi_gs},    8'd0);
    chk("rst_eo",    {7'd0, hi_eo},    8'd0);
    rst = 1'b0; enable = 3'b111;
    tick();
    chk("idle_eo", {7'd0, hi_eo}, 8'd1);
    chk("idle_gs", {7'd0, hi_gs}, 8'd0);

    // Priority order: one-cycle pulse of bits 5,2,0
    in = 8'h25;
    tick();
    in = 8'h00;
    chk("cap_gs",    {7'd0, hi_gs},    8'd1);
    chk("cap_valid", {7'd0, hi_valid}, 8'd0);
    chk("cap_eo",    {7'd0, hi_eo},    8'd0);
    tick();
    chk("lat_valid", {7'd0, hi_valid}, 8'd1);
    grant_ack("g1", 3'd5, 3'd0);
    tick();
    chk("next_grant_timing", {7'd0, hi_valid}, 8'd1);
    grant_ack("g2", 3'd2, 3'd2);
    grant_ack("g3", 3'd0, 3'd5);
    chk("empty_gs", {7'd0, hi_gs}, 8'd0);
    chk("empty_eo", {7'd0, hi_eo}, 8'd1);
    chk("empty_lo_gs", {7'd0, lo_gs}, 8'd0);

    // Handshake hold: no preemption by a higher-priority request
    in = 8'h08;
    tick();
    in = 8'h00;
    tick();
    chk("hold_start", {5'd0, hi_DateA}, 8'd3);
    for (int i = 0; i < 10; i++) begin
      in = (i % 2 == 0) ? 8'h80 : 8'h00;
      tick();
      chk("hold_DateA", {5'd0, hi_DateA}, 8'd3);
      chk("hold_valid", {7'd0, hi_valid}, 8'd1);
    end
    in = 8'h00;
    grant_ack("hold_g", 3'd3, 3'd3);
    grant_ack("after_hold", 3'd7, 3'd7);
    chk("after_hold_gs", {7'd0, hi_gs}, 8'd0);

    // Simultaneous set and clear re-pends the bit
    in = 8'h10;
    tick();
    in = 8'h00;
    tick();
    chk("sc_first", {5'd0, hi_DateA}, 8'd4);
    ack = 1'b1; in = 8'h10;
    tick();
    ack = 1'b0; in = 8'h00;
    chk("sc_valid0", {7'd0, hi_valid}, 8'd0);
    chk("sc_gs",     {7'd0, hi_gs},    8'd1);
    tick();
    chk("sc_regrant_valid", {7'd0, hi_valid}, 8'd1);
    grant_ack("sc_regrant", 3'd4, 3'd4);
    chk("sc_done_eo", {7'd0, hi_eo}, 8'd1);

    // Disabled: no capture
    enable = 3'b110; in = 8'hFF;
    tick(); tick();
    chk("dis_gs",    {7'd0, hi_gs},    8'd0);
    chk("dis_eo",    {7'd0, hi_eo},    8'd0);
    chk("dis_valid", {7'd0, hi_valid}, 8'd0);

    // Disable during PRESENT
    enable = 3'b111; in = 8'h03;
    tick();
    in = 8'h00;
    tick();
    chk("dp_grant", {5'd0, hi_DateA}, 8'd1);
    enable = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dp_hold_valid", {7'd0, hi_valid}, 8'd1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dp_ack_valid", {7'd0, hi_valid}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dp_no_grant", {7'd0, hi_valid}, 8'd0);
      chk("dp_gs_kept",  {7'd0, hi_gs},    8'd1);
    end
    enable = 3'b111;
    tick();
    chk("reen_valid", {7'd0, hi_valid}, 8'd1);
    grant_ack("reen", 3'd0, 3'd1);
    chk("reen_gs", {7'd0, hi_gs}, 8'd0);

    // Mid-operation reset
    in = 8'h0C;
    tick();
    in = 8'h00;
    tick();
    chk("mr_grant", {5'd0, hi_DateA}, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", {7'd0, hi_valid}, 8'd0);
    chk("mr_DateA", {5'd0, hi_DateA}, 8'd0);
    chk("mr_gs",    {7'd0, hi_gs},    8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_grant", {7'd0, hi_valid}, 8'd0);
    end
    chk("mr_eo", {7'd0, hi_eo}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hc148_encoder.md
# hc148_encoder

Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the encoding counterpart of the hc138 3-to-8 decoder. It latches active-high request lines into a pending register and presents the highest-priority pending index on `DateA[2:0]`. That index is held until a consumer acknowledges it, then the serviced request is cleared. Its `DateA` output drives an hc138 `DateA` input directly, which gives a round trip from request to one-hot select.

## Interface
- `PRIO_HIGH`, default 1: 1 = bit 7 highest priority (74HC148 order); 0 = bit 0 highest.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  3  block enabled only when all three bits are 1 (same enable grouping as hc138).
- `in`  in  8  request lines, active-high level, sampled every edge while enabled.
- `ack`  in  1  consumer accepts the presented index; only meaningful while `valid`=1.
- `DateA`  out  3  encoded index of the granted request.
- `valid`  out  1  `DateA` holds an unacknowledged grant.
- `gs`  out  1  group select: at least one request is pending or being presented.
- `eo`  out  1  enable-out for cascading: enabled, nothing pending, nothing presented.

## Operation
- `en` = `&enable`. All outputs are registered; there are no combinational paths from input to output.
- Pending register `pend[7:0]`:
  - Next value: `pend_n = (pend & ~clr) | (en ? in : 8'h00)`.
  - `clr` is the one-hot of `DateA` when `valid` & `ack`, otherwise 0.
  - Set wins over clear: a request on the same bit in the same cycle as its ack re-pends that bit.
- Priority select: `sel` = index of the highest-priority 1 in `pend`, ordered by `PRIO_HIGH`. `sel` is an internal combinational signal.
- State machine, two states:
  - IDLE:
    - If `en` and `pend`≠0: load `DateA`←`sel`, `valid`←1, go to PRESENT.
    - Otherwise stay in IDLE; `valid`=0 and `DateA` holds its last value.
  - PRESENT:
    - `DateA` and `valid` are held stable.
    - On `ack`=1: `valid`←0, clear `pend[DateA]`, go to IDLE.
    - A higher-priority request arriving during PRESENT does not preempt. It is served at the next grant.
- Disable (`en`=0):
  - No new captures and no new grants.
  - `pend` is retained.
  - A grant already in PRESENT completes normally on `ack`.
- `ack` while `valid`=0 is ignored and has no effect on `pend`.
- `gs` ← `(pend_n != 0) | valid_n`.
- `eo` ← `en & (pend_n == 0) & ~valid_n`.
- Reset, applied at any edge including mid-PRESENT:
  - `pend`=0, state IDLE, `DateA`=3'b000, `valid`=0, `gs`=0, `eo`=0.
  - Any outstanding grant is dropped without an ack.

## Timing
- A request high at edge k sets `pend` after edge k, and `gs` is 1 after edge k.
- First grant: `valid`=1 and `DateA` valid after edge k+1. Latency is 2 edges from the sampling edge.
- `ack` sampled at edge m while `valid`=1:
  - `valid`=0 after edge m.
  - The next grant, if anything is still pending, appears after edge m+1.
- Maximum throughput is one grant per 2 cycles.
- `ack` held high continuously gives exactly one clear per grant, because each grant has one PRESENT→IDLE transition.
- A 1-cycle request pulse is captured; the requester does not need to hold the line.
- A request that is already pending and asserts again is a no-op. Requests do not queue, so two pulses on the same bit produce one grant.
- The first edge after `rst` deasserts is the first capture edge.

## Test plan
- Reset then idle:
  - `rst`=1 for 2 cycles → `DateA`=0, `valid`=0, `gs`=0, `eo`=0.
  - Release `rst` with `enable`=3'b111 and `in`=0 → `eo`=1 after 1 edge.
- Priority, `PRIO_HIGH`=1:
  - Pulse `in`=8'b0010_0101 for 1 cycle, then ack each grant → grants in order 5, 2, 0.
  - After the third ack: `gs`=0, `eo`=1.
  - Same stimulus with `PRIO_HIGH`=0 → grants in order 0, 2, 5.
- Handshake hold:
  - Grant 3 presented, `ack` held low for 10 cycles while `in`=8'h80 pulses → `DateA` stays 3 and `valid` stays 1 (no preemption).
  - After ack → next grant is 7.
- Simultaneous set and clear: `in[4]`=1 on the same edge as `ack` for grant 4 → `pend[4]` stays 1 and 4 is granted again 1 edge later.
- Disable:
  - `enable`=3'b110 with `in`=8'hFF → no capture, `gs`=0, `eo`=0.
  - Disable during PRESENT → `valid` stays 1 until `ack`, then no new grant while disabled.
  - Re-enable → pending requests served.
- Mid-operation reset: `rst` pulse while `valid`=1 with `pend`=8'h0C → next cycle `pend`=0, `valid`=0, `DateA`=0, no grant issued afterward until new requests arrive.
